fs_df_sync: RTL and testbench

//  Registered full subtractor: computes d = a - b - c (c = borrow-in) over WIDTH bits.

---
 rtl/fs_df_pkg.sv | 9 +
 rtl/fs_df_bit.sv | 13 +
 rtl/fs_df_sync.sv | 69 ++++++
 tb/tb_fs_df_sync.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_df_pkg.sv
// Shared constants for the fs_df registered full subtractor.
package fs_df_pkg;

    localparam int   FS_DF_WIDTH = 1;
    localparam logic D_RST       = 1'b0;
    localparam logic BA_RST      = 1'b0;
    localparam logic OVF_RST     = 1'b0;

endpackage

// File: rtl/fs_df_bit.sv
// Combinational 1-bit full subtractor cell: d = a - b - c with borrow-out ba.
module fs_df_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic ba
);

    assign d  = a ^ b ^ c;
    assign ba = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/fs_df_sync.sv
// Registered WIDTH-bit ripple-borrow full subtractor: {ba,d} = a - b - c, latency 1.
// Define FS_DF_OVF_EN to add the registered two's-complement overflow output ovf.
module fs_df_sync
    import fs_df_pkg::*;
#(
    parameter int WIDTH = FS_DF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             ba
`ifdef FS_DF_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   bw;
    logic [WIDTH-1:0] d_next;

    assign bw[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fs_df_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .c  (bw[i]),
            .d  (d_next[i]),
            .ba (bw[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= {WIDTH{D_RST}};
            ba        <= BA_RST;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d  <= d_next;
                ba <= bw[WIDTH];
            end
        end
    end

`ifdef FS_DF_OVF_EN
    // Overflow only possible when operand signs differ and the result sign flips from a.
    logic ovf_next;

    assign ovf_next = (a[MSB] ^ b[MSB]) & (d_next[MSB] ^ a[MSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= OVF_RST;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_fs_df_sync.sv
// Scoreboard bench for fs_df_sync at WIDTH=1 and WIDTH=8 (ovf checked when FS_DF_OVF_EN is defined).
module tb_fs_df_sync;

    typedef struct packed {
        logic       d;
        logic       ba;
    } exp1_t;

    typedef struct packed {
        logic [7:0] d;
        logic       ba;
        logic       ovf;
    } exp8_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       out_valid1, d1, ba1;

    logic       in_valid8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic       out_valid8, ba8;
    logic [7:0] d8;
`ifdef FS_DF_OVF_EN
    logic       ovf1, ovf8;
`endif

    exp1_t      q1[$];
    exp8_t      q8[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] hold_d8 = '0;
    logic       hold_ba8 = 1'b0;

    always #5 clk = ~clk;

    fs_df_sync #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .out_valid (out_valid1),
        .d         (d1),
        .ba        (ba1)
`ifdef FS_DF_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    fs_df_sync #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .c         (c8),
        .out_valid (out_valid8),
        .d         (d8),
        .ba        (ba8)
`ifdef FS_DF_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    // Drive one WIDTH=1 vector with its expected result, then advance past the edge.
    task automatic drive1(input logic v, input logic aa, input logic bb, input logic cc,
                          input logic ed, input logic eba);
        exp1_t e;
        in_valid1 = v; a1 = aa; b1 = bb; c1 = cc;
        if (v && !rst) begin
            e.d = ed; e.ba = eba;
            q1.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Drive one WIDTH=8 vector; the expectation comes from integer arithmetic.
    task automatic drive8(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic cc);
        exp8_t e;
        int diff, sdiff;
        in_valid8 = v; a8 = aa; b8 = bb; c8 = cc;
        if (rst) q8.delete();
        if (v && !rst) begin
            diff  = int'(aa) - int'(bb) - int'(cc);
            sdiff = int'($signed(aa)) - int'($signed(bb)) - int'(cc);
            e.d   = diff[7:0];
            e.ba  = diff[8];
            e.ovf = (sdiff > 127) || (sdiff < -128);
            q8.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run += 2;
            if ({out_valid1, d1, ba1} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_w1 cycle %0d: got ov/d/ba=%b expected 000", i, {out_valid1, d1, ba1});
            end
            if ({out_valid8, d8, ba8} !== 10'b0) begin
                tests_failed++;
                $display("FAIL reset_w8 cycle %0d: got ov=%b d=%h ba=%b expected 0/00/0", i, out_valid8, d8, ba8);
            end
        end
        rst = 1'b0; in_valid1 = 1'b0; in_valid8 = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [2:0] abc;
        logic [1:0] tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        exp1_t e;
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            drive1(1'b1, abc[2], abc[1], abc[0], tbl[i][1], tbl[i][0]);
            tests_run++;
            if (out_valid1 !== (q1.size() > 0)) begin
                tests_failed++;
                $display("FAIL tt_valid abc=%b: got %b expected %b", abc, out_valid1, q1.size() > 0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                tests_run++;
                if ({d1, ba1} !== {e.d, e.ba}) begin
                    tests_failed++;
                    $display("FAIL tt_result abc=%b: got d=%b ba=%b expected d=%b ba=%b", abc, d1, ba1, e.d, e.ba);
                end
            end
        end
        in_valid1 = 1'b0;
    endtask

    task automatic test_boundaries();
        exp8_t e;
        drive8(1'b1, 8'h00, 8'hFF, 1'b1);
        e = q8.pop_front();
        tests_run++;
        if ({out_valid8, d8, ba8} !== {1'b1, 8'h00, 1'b1}) begin
            tests_failed++;
            $display("FAIL bound_min: got ov=%b d=%h ba=%b expected 1/00/1", out_valid8, d8, ba8);
        end
        drive8(1'b1, 8'hFF, 8'h00, 1'b0);
        e = q8.pop_front();
        tests_run++;
        if ({out_valid8, d8, ba8} !== {1'b1, 8'hFF, 1'b0}) begin
            tests_failed++;
            $display("FAIL bound_max: got ov=%b d=%h ba=%b expected 1/ff/0", out_valid8, d8, ba8);
        end
        drive8(1'b1, 8'h80, 8'h01, 1'b0);
        e = q8.pop_front();
        tests_run++;
        if ({out_valid8, d8, ba8} !== {1'b1, 8'h7F, 1'b0}) begin
            tests_failed++;
            $display("FAIL bound_80m01: got ov=%b d=%h ba=%b expected 1/7f/0", out_valid8, d8, ba8);
        end
`ifdef FS_DF_OVF_EN
        tests_run++;
        if (ovf8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL bound_ovf: got %b expected 1 (model %b)", ovf8, e.ovf);
        end
`endif
        hold_d8 = 8'h7F; hold_ba8 = 1'b0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            tests_run++;
            if ({out_valid8, d8, ba8} !== {1'b0, hold_d8, hold_ba8}) begin
                tests_failed++;
                $display("FAIL hold cycle %0d: got ov=%b d=%h ba=%b expected 0/%h/%b",
                         i, out_valid8, d8, ba8, hold_d8, hold_ba8);
            end
        end
    endtask

    task automatic test_stream(input string name, input int n);
        exp8_t e;
        for (int i = 0; i < n; i++) begin
            drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            tests_run++;
            if (out_valid8 !== (q8.size() > 0)) begin
                tests_failed++;
                $display("FAIL %s_valid #%0d: got %b expected %b", name, i, out_valid8, q8.size() > 0);
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                tests_run++;
                if ({ba8, d8} !== {e.ba, e.d}) begin
                    tests_failed++;
                    $display("FAIL %s_result #%0d a=%h b=%h c=%b: got ba=%b d=%h expected ba=%b d=%h",
                             name, i, a8, b8, c8, ba8, d8, e.ba, e.d);
                end
`ifdef FS_DF_OVF_EN
                tests_run++;
                if (ovf8 !== e.ovf) begin
                    tests_failed++;
                    $display("FAIL %s_ovf #%0d: got %b expected %b", name, i, ovf8, e.ovf);
                end
`endif
                hold_d8 = e.d; hold_ba8 = e.ba;
            end
        end
        in_valid8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp8_t e;
        drive8(1'b1, 8'h05, 8'h03, 1'b0);
        e = q8.pop_front();
        tests_run++;
        if ({out_valid8, ba8, d8} !== {1'b1, 1'b0, 8'h02}) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got ov=%b ba=%b d=%h expected 1/0/02", out_valid8, ba8, d8);
        end
        rst = 1'b1;
        drive8(1'b1, 8'h10, 8'h20, 1'b1);
        rst = 1'b0;
        tests_run++;
        if ({out_valid8, ba8, d8} !== 10'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: got ov=%b ba=%b d=%h expected 0/0/00", out_valid8, ba8, d8);
        end
        drive8(1'b1, 8'h03, 8'h05, 1'b1);
        tests_run++;
        if (q8.size() != 1 || {out_valid8, ba8, d8} !== {1'b1, 1'b1, 8'hFD}) begin
            tests_failed++;
            $display("FAIL rst_mid_post: got ov=%b ba=%b d=%h expected 1/1/fd", out_valid8, ba8, d8);
        end
        if (q8.size() > 0) e = q8.pop_front();
        in_valid8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_boundaries();
        test_hold();
        test_stream("back_to_back", 16);
        test_hold();
        test_reset_mid();
        test_stream("random", 10000);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
